adc_frame_align: RTL
====================

# adc_frame_align

Frame-pattern aligner and sample assembler for the deserialized ADC lanes. It sits directly downstream of the per-channel 1:SER deserializers and observes the deserialized frame-clock lane. It drives the shared bitslip strobe until the frame word matches the expected pattern, then qualifies and packs multi-lane channel data into full-width samples. It generalises the capture path to any channel count, lane count and serdes factor, and adds lock monitoring, loss-of-lock recovery and a re-align request.

## Interface
- CH, default 8: number of ADC channels.
- LANES, default 2: serial lanes per channel.
- SER, default 8: deserialization factor (bits per lane per clock).
- FRAME_PATTERN, default 8'hF0: expected frame word (SER bits).
- MATCH_COUNT, default 16: consecutive matches required to declare alignment.
- SLIP_WAIT, default 4: settle cycles after each bitslip pulse.
- ERR_LIMIT, default 4: consecutive mismatches while aligned that drop alignment.
- adc_system_clk, in, 1: deserialized-domain clock; the block's only clock.
- adc_system_rst_n, in, 1: asynchronous, active-low reset.
- rx_locked, in, 1: deserializer lock; treated as synchronous to adc_system_clk.
- realign, in, 1: single-cycle request to restart the alignment search.
- frame_word, in, SER: deserialized frame lane.
- lane_data, in, CH×LANES×SER: deserialized data lanes, indexed [ch][lane].
- bitslip, out, 1: one-cycle slip strobe, fanned out to every deserializer.
- aligned, out, 1: frame alignment established.
- align_err, out, 1: sticky; a full rotation of SER slips completed without lock.
- slip_count, out, $clog2(SER+1): slips issued in the current rotation.
- sample_data, out, CH×(LANES×SER): assembled samples; lane LANES-1 occupies the MSBs.
- sample_valid, out, 1: sample_data is qualified.

## Operation
- States: IDLE, CHECK, SLIP, WAIT, LOCKED.
- IDLE: stays here while rx_locked=0, then moves to CHECK. Match counter, error counter and slip_count are all 0.
- CHECK:
  - frame_word==FRAME_PATTERN: the match counter increments. When it reaches MATCH_COUNT, go to LOCKED.
  - Any mismatch clears the match counter and goes to SLIP.
- SLIP: bitslip=1 for exactly one cycle, slip_count increments, then go to WAIT.
  - If the increment would reach SER, slip_count wraps to 0 and align_err is set.
  - The search continues after align_err is set.
- WAIT: SLIP_WAIT cycles with the match check suppressed, then go to CHECK.
- LOCKED: aligned=1.
  - A mismatch increments the error counter; any match clears it.
  - The error counter reaching ERR_LIMIT drops aligned, clears the counters and goes to CHECK. slip_count is retained.
- Any state, rx_locked=0: go to IDLE and clear aligned and all counters. align_err is held.
- Any state except IDLE, realign=1: go to CHECK and clear aligned, counters, slip_count and align_err. realign takes priority over every other transition in that cycle except rx_locked=0.
- Sample assembly: sample_data[ch] = {lane_data[ch][LANES-1], …, lane_data[ch][0]}, registered.
- sample_valid = aligned, delayed to match sample_data.
- sample_data updates every cycle regardless of valid. Consumers must qualify it with sample_valid.

## Timing
- Reset values: bitslip=0, aligned=0, align_err=0, slip_count=0, sample_data=0, sample_valid=0. State is IDLE.
- CHECK→LOCKED: aligned rises on the cycle after the MATCH_COUNT-th consecutive matching frame_word.
- Slip cadence: mismatch in CHECK (cycle n), bitslip at n+1, WAIT for n+2…n+1+SLIP_WAIT, CHECK from n+2+SLIP_WAIT. The minimum spacing between bitslip pulses is SLIP_WAIT+2 cycles.
- Data latency: lane_data→sample_data is 1 cycle. sample_valid is aligned delayed 1 cycle.
- Loss of lock: aligned falls the cycle after the ERR_LIMIT-th consecutive mismatch. sample_valid falls one cycle later.
- All outputs are registered. No combinational path from input to output.

## Test plan
1. **Aligned start.** Reset, rx_locked=1, frame_word=8'hF0 constant -> zero bitslip pulses; aligned=1 after 16 matching cycles; sample_valid one cycle later.
2. **Misaligned start.** Bench model rotates frame_word by 1 bit per slip, with an initial offset of 3 -> exactly 3 bitslip pulses, each SLIP_WAIT+2=6 cycles apart; slip_count=3; aligned=1; align_err=0.
3. **No lock possible.** frame_word stuck at 8'h00 -> after 8 slips slip_count wraps to 0 and align_err=1; bitslip keeps pulsing; a realign pulse clears align_err and slip_count.
4. **Loss of lock.** While LOCKED, inject 3 mismatches then 1 match -> aligned stays 1. Then inject 4 consecutive mismatches -> aligned=0, state CHECK, slips resume.
5. **Sample packing.** CH=8, LANES=2, ch3 lanes {8'hA5 (lane1), 8'h3C (lane0)} -> sample_data[3]=16'hA53C one cycle later, with sample_valid=1.
6. **Mid-operation events.** rx_locked deasserted mid-WAIT -> IDLE next cycle with bitslip=0 and aligned=0. Asynchronous reset asserted while LOCKED -> all outputs immediately return to reset values.

Source files
------------

// File: rtl/adc_frame_align_if.sv
// rtl/adc_frame_align_if.sv - deserializer-side lanes, control and assembled-sample bundle
interface adc_frame_align_if #(
  parameter int CH    = 8,
  parameter int LANES = 2,
  parameter int SER   = 8
);
  localparam int DW  = CH * LANES * SER;
  localparam int SCW = $clog2(SER + 1);

  // lane_data is flattened channel-major, lane-minor: word [ch][lane] at bit (ch*LANES+lane)*SER
  logic           rx_locked;
  logic           realign;
  logic [SER-1:0] frame_word;
  logic [DW-1:0]  lane_data;

  logic           bitslip;
  logic           aligned;
  logic           align_err;
  logic [SCW-1:0] slip_count;
  logic [DW-1:0]  sample_data;
  logic           sample_valid;

  modport master (
    output rx_locked, realign, frame_word, lane_data,
    input  bitslip, aligned, align_err, slip_count, sample_data, sample_valid
  );

  modport slave (
    input  rx_locked, realign, frame_word, lane_data,
    output bitslip, aligned, align_err, slip_count, sample_data, sample_valid
  );
endinterface

// File: rtl/adc_frame_align.sv
// rtl/adc_frame_align.sv - frame-pattern bitslip aligner and multi-lane sample assembler
module adc_frame_align #(
  parameter int             CH            = 8,
  parameter int             LANES         = 2,
  parameter int             SER           = 8,
  parameter logic [SER-1:0] FRAME_PATTERN = 8'hF0,
  parameter int             MATCH_COUNT   = 16,
  parameter int             SLIP_WAIT     = 4,
  parameter int             ERR_LIMIT     = 4
) (
  input  logic               adc_system_clk,
  input  logic               adc_system_rst_n,
  adc_frame_align_if.slave   bus
);

  localparam int DW  = CH * LANES * SER;
  localparam int CW  = LANES * SER;
  localparam int SCW = $clog2(SER + 1);
  localparam int MW  = $clog2(MATCH_COUNT + 1);
  localparam int EW  = $clog2(ERR_LIMIT + 1);
  localparam int WW  = $clog2(SLIP_WAIT + 1);

  localparam logic [MW-1:0]  MATCH_LAST = MW'(MATCH_COUNT - 1);
  localparam logic [EW-1:0]  ERR_LAST   = EW'(ERR_LIMIT - 1);
  localparam logic [WW-1:0]  WAIT_LAST  = WW'(SLIP_WAIT - 1);
  localparam logic [SCW-1:0] SLIP_LAST  = SCW'(SER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SLIP,
    S_WAIT,
    S_LOCKED
  } state_t;

  state_t         state_q, state_d;
  logic [MW-1:0]  match_cnt_q, match_cnt_d;
  logic [EW-1:0]  err_cnt_q, err_cnt_d;
  logic [WW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [SCW-1:0] slip_cnt_q, slip_cnt_d;
  logic           aligned_q, aligned_d;
  logic           align_err_q, align_err_d;
  logic           bitslip_q, bitslip_d;
  logic [DW-1:0]  sample_q, sample_d;
  logic           valid_q;
  logic           frame_ok;

  assign frame_ok = (bus.frame_word == FRAME_PATTERN);

  // Next-state logic: lock loss beats realign, realign beats the normal search/track flow
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    err_cnt_d   = err_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    slip_cnt_d  = slip_cnt_q;
    aligned_d   = aligned_q;
    align_err_d = align_err_q;
    bitslip_d   = 1'b0;

    if (!bus.rx_locked) begin
      state_d     = S_IDLE;
      aligned_d   = 1'b0;
      match_cnt_d = '0;
      err_cnt_d   = '0;
      wait_cnt_d  = '0;
      slip_cnt_d  = '0;
    end else if (bus.realign && (state_q != S_IDLE)) begin
      state_d     = S_CHECK;
      aligned_d   = 1'b0;
      match_cnt_d = '0;
      err_cnt_d   = '0;
      wait_cnt_d  = '0;
      slip_cnt_d  = '0;
      align_err_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_CHECK;
        end
        S_CHECK: begin
          if (frame_ok) begin
            if (match_cnt_q == MATCH_LAST) begin
              state_d     = S_LOCKED;
              aligned_d   = 1'b1;
              match_cnt_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end else begin
            // The strobe and the slip count are registered together on entry to SLIP
            match_cnt_d = '0;
            state_d     = S_SLIP;
            bitslip_d   = 1'b1;
            if (slip_cnt_q == SLIP_LAST) begin
              slip_cnt_d  = '0;
              align_err_d = 1'b1;
            end else begin
              slip_cnt_d = slip_cnt_q + 1'b1;
            end
          end
        end
        S_SLIP: begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
        S_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_d    = S_CHECK;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        S_LOCKED: begin
          if (frame_ok) begin
            err_cnt_d = '0;
          end else if (err_cnt_q == ERR_LAST) begin
            state_d     = S_CHECK;
            aligned_d   = 1'b0;
            err_cnt_d   = '0;
            match_cnt_d = '0;
          end else begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Alignment state and status registers
  always_ff @(posedge adc_system_clk or negedge adc_system_rst_n) begin
    if (!adc_system_rst_n) begin
      state_q     <= S_IDLE;
      match_cnt_q <= '0;
      err_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      slip_cnt_q  <= '0;
      aligned_q   <= 1'b0;
      align_err_q <= 1'b0;
      bitslip_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      err_cnt_q   <= err_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      slip_cnt_q  <= slip_cnt_d;
      aligned_q   <= aligned_d;
      align_err_q <= align_err_d;
      bitslip_q   <= bitslip_d;
    end
  end

  // Concatenate each channel's lanes with the highest lane in the MSBs
  always_comb begin
    sample_d = '0;
    for (int ch = 0; ch < CH; ch++) begin
      for (int ln = 0; ln < LANES; ln++) begin
        sample_d[ch*CW + ln*SER +: SER] = bus.lane_data[(ch*LANES + ln)*SER +: SER];
      end
    end
  end

  // Sample register; valid is aligned delayed one cycle so it lines up with the data
  always_ff @(posedge adc_system_clk or negedge adc_system_rst_n) begin
    if (!adc_system_rst_n) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      sample_q <= sample_d;
      valid_q  <= aligned_q;
    end
  end

  assign bus.bitslip      = bitslip_q;
  assign bus.aligned      = aligned_q;
  assign bus.align_err    = align_err_q;
  assign bus.slip_count   = slip_cnt_q;
  assign bus.sample_data  = sample_q;
  assign bus.sample_valid = valid_q;

endmodule
